mc_rf_timer: RTL and testbench

- Refresh scheduler for the memory controller core. It sits directly downstream of the APB configuration register block.
- Consumes mc_en, mc_rf_start_time_cfg and mc_rf_period_time_cfg, and generates periodic refresh ticks.
- Keeps a count of postponed refreshes and presents a req/ack refresh request to the command arbiter, with urgency and overflow flags.

---
 rtl/mc_rf_timer_if.sv | 11 +
 rtl/mc_rf_timer.sv | 79 +++++++
 tb/tb_mc_rf_timer.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/mc_rf_timer_if.sv
// mc_rf_timer_if: refresh request bundle between the refresh timer (master) and the command arbiter (slave).
interface mc_rf_timer_if #(parameter int PEND_WIDTH = 4);
  logic                  rf_req;
  logic                  rf_ack;
  logic                  rf_urgent;
  logic [PEND_WIDTH-1:0] rf_pend_cnt;
  logic                  rf_overflow;
  logic [15:0]           rf_issue_cnt;
  modport master (output rf_req, rf_urgent, rf_pend_cnt, rf_overflow, rf_issue_cnt, input rf_ack);
  modport slave (input rf_req, rf_urgent, rf_pend_cnt, rf_overflow, rf_issue_cnt, output rf_ack);
endinterface

// File: rtl/mc_rf_timer.sv
// mc_rf_timer: periodic refresh scheduler with pending counter and req/ack to the arbiter.
// Define MC_RF_DBG_CNT_EN to get a live rf_issue_cnt; otherwise it reads 0.
module mc_rf_timer #(
  parameter int CNT_WIDTH  = 28,
  parameter int PEND_WIDTH = 4,
  parameter int MAX_PEND   = 8,
  parameter int URGENT_TH  = 6
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 mc_en,
  input  logic [CNT_WIDTH-1:0] mc_rf_start_time_cfg,
  input  logic [CNT_WIDTH-1:0] mc_rf_period_time_cfg,
  mc_rf_timer_if.master        rf
);
  typedef enum logic [1:0] {IDLE, WAIT_START, RUN} state_e;
  state_e                state_q, state_d;
  logic [CNT_WIDTH-1:0]  timer_q, timer_d, start_ld, period_ld;
  logic [PEND_WIDTH-1:0] pend_q, pend_d;
  logic                  ovf_q, ovf_d, active, tick, accept, at_max;
  always_comb begin
    start_ld  = (mc_rf_start_time_cfg == '0) ? CNT_WIDTH'(1) : mc_rf_start_time_cfg;
    period_ld = (mc_rf_period_time_cfg == '0) ? CNT_WIDTH'(1) : mc_rf_period_time_cfg;
    active    = (state_q != IDLE) && mc_en;
    tick      = active && (timer_q == CNT_WIDTH'(1));
    accept    = active && rf.rf_req && rf.rf_ack;
    at_max    = (pend_q == PEND_WIDTH'(MAX_PEND));
    state_d   = state_q;
    timer_d   = timer_q;
    pend_d    = pend_q;
    ovf_d     = ovf_q;
    if (state_q == IDLE) begin
      timer_d = mc_en ? start_ld : '0;
      state_d = mc_en ? WAIT_START : IDLE;
    end else if (!mc_en) begin
      state_d = IDLE;
      timer_d = '0;
      pend_d  = '0;
      ovf_d   = 1'b0;
    end else begin
      timer_d = tick ? period_ld : timer_q - CNT_WIDTH'(1);
      state_d = tick ? RUN : state_q;
      // a tick that finds the counter saturated is dropped and remembered
      if (tick && !accept) begin
        pend_d = at_max ? pend_q : pend_q + PEND_WIDTH'(1);
        ovf_d  = ovf_q | at_max;
      end else if (accept && !tick) begin
        pend_d = pend_q - PEND_WIDTH'(1);
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      timer_q <= '0;
      pend_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      pend_q  <= pend_d;
      ovf_q   <= ovf_d;
    end
  end
  assign rf.rf_req      = (pend_q != '0);
  assign rf.rf_urgent   = (pend_q >= PEND_WIDTH'(URGENT_TH));
  assign rf.rf_pend_cnt = pend_q;
  assign rf.rf_overflow = ovf_q;
`ifdef MC_RF_DBG_CNT_EN
  logic [15:0] issue_q;
  always_ff @(posedge clk) begin
    if (rst) issue_q <= '0;
    else if (accept) issue_q <= issue_q + 16'd1;
  end
  assign rf.rf_issue_cnt = issue_q;
`else
  assign rf.rf_issue_cnt = '0;
`endif
endmodule

// File: tb/tb_mc_rf_timer.sv
// tb_mc_rf_timer: table, directed and random checks of mc_rf_timer against an absolute-time reference model.
module tb_mc_rf_timer;
  logic        clk = 1'b0;
  logic        rst, mc_en;
  logic [27:0] s_cfg, p_cfg;
  int          tests = 0, fails = 0;
  mc_rf_timer_if #(.PEND_WIDTH(4)) rf_if ();
  mc_rf_timer dut (
    .clk(clk), .rst(rst), .mc_en(mc_en),
    .mc_rf_start_time_cfg(s_cfg), .mc_rf_period_time_cfg(p_cfg), .rf(rf_if)
  );
  always #5 clk = ~clk;
  // model: ticks are scheduled as absolute edge numbers, pending is a plain integer
  longint cyc = 0, next_tick = 0;
  bit     m_en = 0, m_ovf = 0;
  int     m_pend = 0, m_issue = 0;
  function automatic longint mx1(input int v);
    return (v == 0) ? 1 : v;
  endfunction
  task automatic ck(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, cyc);
    end
  endtask
  task automatic drive(input bit r, input bit e, input int s, input int p, input bit a);
    rst = r; mc_en = e; s_cfg = 28'(s); p_cfg = 28'(p); rf_if.rf_ack = a;
  endtask
  task automatic step();
    bit tk, acc;
    @(posedge clk);
    cyc++;
    if (rst) begin
      m_en = 0; m_pend = 0; m_ovf = 0; m_issue = 0;
    end else if (!m_en) begin
      if (mc_en) begin
        m_en = 1; next_tick = cyc + mx1(int'(s_cfg));
      end
    end else if (!mc_en) begin
      m_en = 0; m_pend = 0; m_ovf = 0;
    end else begin
      tk = (cyc == next_tick);
      acc = (m_pend > 0) && rf_if.rf_ack;
      if (tk) next_tick = cyc + mx1(int'(p_cfg));
      if (tk && !acc) begin
        if (m_pend == 8) m_ovf = 1; else m_pend++;
      end else if (acc && !tk) m_pend--;
      if (acc) m_issue = (m_issue + 1) & 16'hFFFF;
    end
    #1;
    ck("pend", int'(rf_if.rf_pend_cnt), m_pend);
    ck("req", int'(rf_if.rf_req), int'(m_pend != 0));
    ck("urgent", int'(rf_if.rf_urgent), int'(m_pend >= 6));
    ck("overflow", int'(rf_if.rf_overflow), int'(m_ovf));
`ifdef MC_RF_DBG_CNT_EN
    ck("issue", int'(rf_if.rf_issue_cnt), m_issue);
`else
    ck("issue", int'(rf_if.rf_issue_cnt), 0);
`endif
  endtask
  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask
  typedef struct {bit r; bit e; int s; int p; bit a; int pend; bit ovf;} vec_t;
  vec_t tbl[22];
  int   exp_p[22] = '{0,0,0,0,0,1,1,1,1,1,2,2,2,2,2,3,2,1,0,0,1,0};
  initial begin
    for (int i = 0; i < 22; i++)
      tbl[i] = '{r: (i < 2), e: (i >= 2 && i != 21), s: 3, p: 5, a: (i >= 16 && i <= 19), pend: exp_p[i], ovf: 0};
    drive(1, 0, 3, 5, 0);
    for (int i = 0; i < 22; i++) begin
      drive(tbl[i].r, tbl[i].e, tbl[i].s, tbl[i].p, tbl[i].a);
      step();
      ck($sformatf("tbl_pend[%0d]", i), int'(rf_if.rf_pend_cnt), tbl[i].pend);
      ck($sformatf("tbl_req[%0d]", i), int'(rf_if.rf_req), int'(tbl[i].pend != 0));
      ck($sformatf("tbl_ovf[%0d]", i), int'(rf_if.rf_overflow), int'(tbl[i].ovf));
    end
    // saturation with period 1, then drain with a long period
    drive(0, 1, 1, 1, 0);
    for (int i = 0; i < 10; i++) begin
      step();
      ck("sat_pend", int'(rf_if.rf_pend_cnt), (i > 8) ? 8 : i);
      ck("sat_urgent", int'(rf_if.rf_urgent), int'(i >= 6));
    end
    ck("sat_ovf", int'(rf_if.rf_overflow), 1);
    drive(0, 1, 1, 1000, 1);
    steps(9);
    ck("drain_pend", int'(rf_if.rf_pend_cnt), 0);
    ck("drain_ovf", int'(rf_if.rf_overflow), 1);
    drive(0, 0, 1, 1, 0);
    step();
    ck("dis_ovf", int'(rf_if.rf_overflow), 0);
    // tick+accept at saturation is not an overflow
    drive(0, 1, 1, 1, 0);
    steps(9);
    ck("max_pend", int'(rf_if.rf_pend_cnt), 8);
    drive(0, 1, 1, 1, 1);
    step();
    ck("max_ta_pend", int'(rf_if.rf_pend_cnt), 8);
    ck("max_ta_ovf", int'(rf_if.rf_overflow), 0);
    // tick+accept at pending 2
    drive(0, 0, 1, 4, 0); step();
    drive(0, 1, 1, 4, 0); steps(9);
    ck("p2_pend", int'(rf_if.rf_pend_cnt), 2);
    drive(0, 1, 1, 4, 1); step();
    ck("p2_ta_pend", int'(rf_if.rf_pend_cnt), 2);
    ck("p2_ta_ovf", int'(rf_if.rf_overflow), 0);
    // reset in the middle of the start countdown
    drive(0, 0, 50, 4, 0); step();
    drive(0, 1, 50, 4, 0); steps(3);
    drive(1, 1, 50, 4, 0); step();
    ck("rst_req", int'(rf_if.rf_req), 0);
    ck("rst_pend", int'(rf_if.rf_pend_cnt), 0);
    // re-enable with start 4
    drive(0, 0, 4, 9, 0); step();
    drive(0, 1, 4, 9, 0); steps(4);
    ck("s4_before", int'(rf_if.rf_pend_cnt), 0);
    step();
    ck("s4_tick", int'(rf_if.rf_pend_cnt), 1);
    // zero cfg acts as 1
    drive(0, 0, 0, 0, 0); step();
    drive(0, 1, 0, 0, 0); steps(4);
    ck("zero_cfg", int'(rf_if.rf_pend_cnt), 3);
    // period change mid-run takes effect at the next reload
    drive(0, 0, 1, 5, 0); step();
    drive(0, 1, 1, 5, 0); steps(2);
    drive(0, 1, 1, 2, 0); steps(4);
    ck("pchg_hold", int'(rf_if.rf_pend_cnt), 1);
    step();
    ck("pchg_tick", int'(rf_if.rf_pend_cnt), 2);
    steps(2);
    ck("pchg_new", int'(rf_if.rf_pend_cnt), 3);
    // ack without req
    drive(0, 0, 10, 10, 1); step();
    drive(0, 1, 10, 10, 1); steps(3);
    ck("ack_noreq", int'(rf_if.rf_pend_cnt), 0);
    // random stimulus against the model
    for (int i = 0; i < 2000; i++) begin
      drive($urandom_range(0, 199) == 0, $urandom_range(0, 29) != 0,
            int'($urandom_range(0, 6)), int'($urandom_range(0, 6)), $urandom_range(0, 2) == 0);
      step();
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
